// File: rtl/bcd_ctrl_pkg.sv
// Shared definitions for the BCD counter sequencing controller: state codes
// and default limits.
package bcd_ctrl_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] ARM   = 3'd2;
  localparam logic [2:0] RUN   = 3'd3;
  localparam logic [2:0] HOLD  = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  localparam logic [2:0] FAULT = 3'd6;

  localparam int MAX_LIMIT_DEF = 99;
  localparam int TIMEOUT_DEF   = 1023;

  typedef enum logic [2:0] {
    ST_IDLE  = IDLE,
    ST_CLEAR = CLEAR,
    ST_ARM   = ARM,
    ST_RUN   = RUN,
    ST_HOLD  = HOLD,
    ST_DONE  = DONE,
    ST_FAULT = FAULT
  } state_t;

endpackage

// File: rtl/bcd_count_ctrl_if.sv
// Signal bundle between panel inputs, the BCD counter and the controller.
// The controller is the master; the panel/counter side is the slave.
interface bcd_count_ctrl_if;
  logic       start;
  logic       hold;
  logic       abort;
  logic [6:0] max_in;
  logic [3:0] digit_tens;
  logic [3:0] digit_ones;
  logic [6:0] max_count;
  logic       run;
  logic       clr;
  logic       done;
  logic       err;
  logic [2:0] state;

  modport master (
    input  start, hold, abort, max_in, digit_tens, digit_ones,
    output max_count, run, clr, done, err, state
  );

  modport slave (
    output start, hold, abort, max_in, digit_tens, digit_ones,
    input  max_count, run, clr, done, err, state
  );
endinterface

// File: rtl/bcd_count_ctrl_bin2bcd_7.sv
// Combinational 7-bit binary to two BCD digits; valid for inputs 0..99.
module bin2bcd_7 (
  input  logic [6:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  assign tens = 4'(bin / 7'd10);
  assign ones = 4'(bin % 7'd10);

endmodule

// File: rtl/bcd_count_ctrl.sv
// Sequencing controller for the two-digit BCD counter: target latch, clear
// pulse, run enable, terminal/stall/illegal-digit detection.
module bcd_count_ctrl
  import bcd_ctrl_pkg::*;
#(
  parameter int MAX_LIMIT = MAX_LIMIT_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int TW        = 10
) (
  input logic             CLK,
  input logic             RST,
  bcd_count_ctrl_if.master bus
);

  localparam logic [6:0]    LIMIT  = 7'(MAX_LIMIT);
  localparam logic [TW-1:0] WD_MAX = TW'(TIMEOUT);

  state_t        cur, nxt;
  logic          start_prev, abort_prev;
  logic          start_edge, abort_edge;
  logic [6:0]    tgt;
  logic [3:0]    tgt_tens, tgt_ones;
  logic [7:0]    dig_prev;
  logic [TW-1:0] wd;
  logic          digit_bad, match, dig_change, latch_en;

  function automatic logic [6:0] clamp_tgt(input logic [6:0] v);
    return (v > LIMIT) ? LIMIT : v;
  endfunction

  bin2bcd_7 u_tgt_bcd (
    .bin  (tgt),
    .tens (tgt_tens),
    .ones (tgt_ones)
  );

  assign start_edge = bus.start & ~start_prev;
  assign abort_edge = bus.abort & ~abort_prev;
  assign digit_bad  = (bus.digit_tens > 4'd9) || (bus.digit_ones > 4'd9);
  assign match      = ({bus.digit_tens, bus.digit_ones} == {tgt_tens, tgt_ones});
  assign dig_change = ({bus.digit_tens, bus.digit_ones} != dig_prev);
  // Abort is ignored in IDLE but otherwise beats a simultaneous start.
  assign latch_en   = start_edge &&
                      ((cur == ST_IDLE) ||
                       (!abort_edge && (cur == ST_DONE || cur == ST_FAULT)));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      start_prev <= 1'b1;
      abort_prev <= 1'b1;
      dig_prev   <= '0;
      tgt        <= '0;
    end else begin
      start_prev <= bus.start;
      abort_prev <= bus.abort;
      dig_prev   <= {bus.digit_tens, bus.digit_ones};
      if (latch_en) tgt <= clamp_tgt(bus.max_in);
    end
  end

  // Watchdog: cleared in ARM and on any digit movement, frozen outside RUN.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wd <= '0;
    end else if (cur == ST_ARM) begin
      wd <= '0;
    end else if (cur == ST_RUN) begin
      if (dig_change)        wd <= '0;
      else if (wd != WD_MAX) wd <= wd + 1'b1;
    end
  end

  always_comb begin
    nxt = cur;
    case (cur)
      ST_IDLE:  if (latch_en) nxt = ST_CLEAR;
      ST_CLEAR: nxt = ST_ARM;
      ST_ARM:   nxt = ST_RUN;
      ST_RUN: begin
        if (abort_edge)        nxt = ST_IDLE;
        else if (digit_bad)    nxt = ST_FAULT;
        else if (match)        nxt = ST_DONE;
        else if (bus.hold)     nxt = ST_HOLD;
        else if (wd == WD_MAX) nxt = ST_FAULT;
      end
      ST_HOLD: begin
        if (abort_edge)     nxt = ST_IDLE;
        else if (!bus.hold) nxt = ST_RUN;
      end
      ST_DONE, ST_FAULT: begin
        if (abort_edge)    nxt = ST_IDLE;
        else if (latch_en) nxt = ST_CLEAR;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // Moore outputs registered from the next state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cur      <= ST_IDLE;
      bus.run  <= 1'b0;
      bus.clr  <= 1'b0;
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
    end else begin
      cur      <= nxt;
      bus.run  <= (nxt == ST_RUN);
      bus.clr  <= (nxt == ST_CLEAR);
      bus.done <= (nxt == ST_DONE);
      bus.err  <= (nxt == ST_FAULT);
    end
  end

  assign bus.state     = cur;
  assign bus.max_count = tgt;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Directed-vector bench for bcd_count_ctrl, driving the counter digits by hand.
module tb_bcd_count_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  bcd_count_ctrl_if bus ();

  bcd_count_ctrl #(.MAX_LIMIT(99), .TIMEOUT(16), .TW(5)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_dig(input logic [3:0] t, input logic [3:0] o);
    bus.digit_tens = t;
    bus.digit_ones = o;
  endtask

  // Start edge then CLEAR -> ARM -> RUN, checking the documented latency.
  task automatic launch(input logic [6:0] m, input logic [6:0] exp_max, input string tag);
    bus.max_in = m;
    bus.start  = 1'b1;
    step();
    chk({tag, "_clr_state"}, 32'(bus.state), 1);
    chk({tag, "_clr"}, 32'(bus.clr), 1);
    chk({tag, "_max_count"}, 32'(bus.max_count), 32'(exp_max));
    bus.start = 1'b0;
    step();
    chk({tag, "_arm_state"}, 32'(bus.state), 2);
    chk({tag, "_arm_clr"}, 32'(bus.clr), 0);
    step();
    chk({tag, "_run"}, 32'(bus.run), 1);
  endtask

  initial begin
    bus.start  = 1'b1;
    bus.hold   = 1'b0;
    bus.abort  = 1'b0;
    bus.max_in = 7'd50;
    set_dig(4'd0, 4'd0);

    repeat (2) step();
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_run", 32'(bus.run), 0);
    chk("rst_max_count", 32'(bus.max_count), 0);
    chk("rst_flags", 32'({bus.clr, bus.done, bus.err}), 0);

    RST = 1'b0;
    repeat (3) step();
    chk("held_start_state", 32'(bus.state), 0);
    chk("held_start_run", 32'(bus.run), 0);
    bus.start = 1'b0;
    step();

    // Normal run to 50
    launch(7'd50, 7'd50, "norm");
    begin
      int bad = 0;
      for (int v = 0; v <= 50; v++) begin
        set_dig(4'(v / 10), 4'(v % 10));
        step();
        if (v < 50 && (bus.run !== 1'b1 || bus.state !== 3'd3)) bad++;
      end
      chk("norm_counting", bad, 0);
    end
    chk("norm_done", 32'(bus.done), 1);
    chk("norm_done_run", 32'(bus.run), 0);
    chk("norm_done_state", 32'(bus.state), 5);

    // Abort and start together in DONE
    bus.abort = 1'b1;
    bus.start = 1'b1;
    step();
    chk("abort_prio_state", 32'(bus.state), 0);
    chk("abort_prio_done", 32'(bus.done), 0);
    bus.abort = 1'b0;
    bus.start = 1'b0;
    step();

    // Clamp and hold
    launch(7'd120, 7'd99, "clamp");
    for (int v = 0; v <= 40; v++) begin
      set_dig(4'(v / 10), 4'(v % 10));
      step();
    end
    bus.hold = 1'b1;
    step();
    chk("hold_state", 32'(bus.state), 4);
    chk("hold_run", 32'(bus.run), 0);
    begin
      int bad = 0;
      for (int i = 0; i < 19; i++) begin
        step();
        if (bus.state !== 3'd4 || bus.run !== 1'b0) bad++;
      end
      chk("hold_steady", bad, 0);
    end
    bus.hold = 1'b0;
    step();
    chk("resume_run", 32'(bus.run), 1);
    repeat (2) step();
    chk("resume_wd_frozen", 32'(bus.state), 3);
    for (int v = 41; v <= 99; v++) begin
      set_dig(4'(v / 10), 4'(v % 10));
      step();
    end
    chk("clamp_done", 32'(bus.done), 1);
    chk("clamp_done_state", 32'(bus.state), 5);

    // Stall at 3,7
    set_dig(4'd3, 4'd7);
    launch(7'd50, 7'd50, "stall");
    begin
      int bad = 0;
      for (int i = 0; i < 16; i++) begin
        step();
        if (bus.state !== 3'd3) bad++;
      end
      chk("stall_pre", bad, 0);
    end
    step();
    chk("stall_state", 32'(bus.state), 6);
    chk("stall_err", 32'(bus.err), 1);
    chk("stall_run", 32'(bus.run), 0);

    // Restart from FAULT, then illegal BCD with hold
    set_dig(4'd0, 4'd0);
    launch(7'd50, 7'd50, "refire");
    bus.hold = 1'b1;
    set_dig(4'd0, 4'hA);
    step();
    chk("illegal_state", 32'(bus.state), 6);
    chk("illegal_err", 32'(bus.err), 1);
    bus.hold = 1'b0;
    set_dig(4'd0, 4'd0);

    // Abort during HOLD
    launch(7'd50, 7'd50, "habort");
    bus.hold = 1'b1;
    step();
    chk("habort_hold", 32'(bus.state), 4);
    bus.abort = 1'b1;
    step();
    chk("habort_state", 32'(bus.state), 0);
    chk("habort_run", 32'(bus.run), 0);
    bus.abort = 1'b0;
    bus.hold  = 1'b0;
    step();

    // Zero target finishes on first RUN cycle
    launch(7'd0, 7'd0, "zero");
    step();
    chk("zero_done", 32'(bus.done), 1);
    chk("zero_state", 32'(bus.state), 5);

    // Asynchronous reset mid-RUN
    set_dig(4'd2, 4'd4);
    launch(7'd50, 7'd50, "arst");
    #3;
    RST = 1'b1;
    #1;
    chk("arst_state", 32'(bus.state), 0);
    chk("arst_outs", 32'({bus.run, bus.clr, bus.done, bus.err}), 0);
    chk("arst_max_count", 32'(bus.max_count), 0);
    step();
    RST = 1'b0;
    step();
    chk("arst_after", 32'(bus.state), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
